// File: rtl/apb_pkg.sv
// Shared FSM encoding and default widths for the APB master slice.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int unsigned APB_ADDR_W         = 4;
    localparam int unsigned APB_DATA_W         = 32;
    localparam int unsigned APB_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter; expired flags the edge that would be the TIMEOUT_CYCLES-th wait.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] count;

    // Counts completed wait edges, so the abort edge is the one seen while count == limit-1.
    assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-command APB requester: valid/ready command in, one-cycle response strobe out.
// Optional ACCESS timeout abort is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDRESSWIDTH   = APB_ADDR_W,
    parameter int unsigned DATAWIDTH      = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESSWIDTH-1:0] cmd_addr,
    input  logic [DATAWIDTH-1:0]    cmd_wdata,
    output logic                    rsp_valid,
    output logic [DATAWIDTH-1:0]    rsp_rdata,
    output logic                    rsp_error,
    output logic [ADDRESSWIDTH-1:0] PADDR,
    output logic [DATAWIDTH-1:0]    PWDATA,
    output logic                    PWRITE,
    output logic                    PSELx,
    output logic                    PENABLE,
    input  logic [DATAWIDTH-1:0]    PRDATA,
    input  logic                    PREADY
);

    apb_state_t state;

    assign cmd_ready = (state == IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
    logic timer_clear;
    logic timer_inc;
    logic timer_expired;

    assign timer_clear = (state == SETUP);
    assign timer_inc   = (state == ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (PCLK),
        .rst    (PRESET),
        .clear  (timer_clear),
        .inc    (timer_inc),
        .expired(timer_expired)
    );
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PADDR   <= cmd_addr;
                        PWRITE  <= cmd_write;
                        PWDATA  <= cmd_write ? cmd_wdata : '0;
                        PSELx   <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY is checked first so a completion on the terminal wait edge wins over abort.
                    if (PREADY) begin
                        PSELx     <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        state     <= IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (timer_expired) begin
                        PSELx     <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master; the bench plays the APB slave and keeps a reference memory.
module tb_apb_master;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSELx;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    logic [31:0] slave_mem [16];
    logic [31:0] ref_mem   [16];

    apb_master #(
        .ADDRESSWIDTH  (4),
        .DATAWIDTH     (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PSELx    (PSELx),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One complete transfer with a given number of PREADY=0 ACCESS cycles.
    task automatic xfer(input logic wr, input logic [3:0] a, input logic [31:0] d,
                        input int unsigned waits);
        logic [31:0] exp_rd;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        PREADY    = 1'b0;
        chk("idle_ready", {31'b0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 4'($urandom);
        cmd_wdata = $urandom;
        chk("setup_psel",   {31'b0, PSELx},   32'd1);
        chk("setup_penable", {31'b0, PENABLE}, 32'd0);
        chk("setup_paddr",  {28'b0, PADDR},   {28'b0, a});
        chk("setup_pwrite", {31'b0, PWRITE},  {31'b0, wr});
        chk("setup_pwdata", PWDATA,           wr ? d : 32'd0);
        chk("busy_ready",   {31'b0, cmd_ready}, 32'd0);
        tick();
        chk("access_penable", {31'b0, PENABLE}, 32'd1);
        chk("access_psel",    {31'b0, PSELx},   32'd1);
        for (int i = 0; i < int'(waits); i++) begin
            tick();
            chk("wait_psel",    {31'b0, PSELx},     32'd1);
            chk("wait_penable", {31'b0, PENABLE},   32'd1);
            chk("wait_paddr",   {28'b0, PADDR},     {28'b0, a});
            chk("wait_pwdata",  PWDATA,             wr ? d : 32'd0);
            chk("wait_rsp",     {31'b0, rsp_valid}, 32'd0);
            chk("wait_ready",   {31'b0, cmd_ready}, 32'd0);
        end
        exp_rd = wr ? 32'd0 : ref_mem[a];
        if (wr) ref_mem[a] = d;
        PREADY = 1'b1;
        PRDATA = PWRITE ? $urandom : slave_mem[PADDR];
        if (PWRITE) slave_mem[PADDR] = PWDATA;
        tick();
        PREADY = 1'b0;
        PRDATA = $urandom;
        chk("rsp_valid",    {31'b0, rsp_valid}, 32'd1);
        chk("rsp_error",    {31'b0, rsp_error}, 32'd0);
        chk("rsp_rdata",    rsp_rdata,          exp_rd);
        chk("done_psel",    {31'b0, PSELx},     32'd0);
        chk("done_penable", {31'b0, PENABLE},   32'd0);
        chk("done_ready",   {31'b0, cmd_ready}, 32'd1);
        chk("hold_paddr",   {28'b0, PADDR},     {28'b0, a});
        tick();
        chk("rsp_pulse",  {31'b0, rsp_valid}, 32'd0);
        chk("rsp_hold",   rsp_rdata,          exp_rd);
    endtask

    initial begin
        logic [3:0]  ra;
        logic [31:0] rd;
        logic        rw;
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i]   = slave_mem[i];
        end
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ready",   {31'b0, cmd_ready}, 32'd1);
        chk("rst_rsp",     {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata",   rsp_rdata,          32'd0);
        chk("rst_error",   {31'b0, rsp_error}, 32'd0);
        chk("rst_paddr",   {28'b0, PADDR},     32'd0);
        chk("rst_pwdata",  PWDATA,             32'd0);
        chk("rst_psel",    {31'b0, PSELx},     32'd0);
        chk("rst_penable", {31'b0, PENABLE},   32'd0);
        PRESET = 1'b0;
        tick();

        // Directed write then read-back, then a slow slave
        xfer(1'b1, 4'd4, 32'h0000000F, 0);
        xfer(1'b0, 4'd4, 32'hDEADBEEF, 0);
        xfer(1'b0, 4'd4, 32'h0, 3);

        // Back-to-back writes with cmd_valid held high
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'd1;
        cmd_wdata = 32'h11111111;
        PREADY    = 1'b1;
        tick();
        chk("b2b_paddr1", {28'b0, PADDR}, 32'd1);
        chk("b2b_ready1", {31'b0, cmd_ready}, 32'd0);
        cmd_addr  = 4'd2;
        cmd_wdata = 32'h22222222;
        tick();
        chk("b2b_access_ready", {31'b0, cmd_ready}, 32'd0);
        slave_mem[PADDR] = PWDATA;
        ref_mem[1] = 32'h11111111;
        tick();
        chk("b2b_rsp1",   {31'b0, rsp_valid}, 32'd1);
        chk("b2b_ready_gap", {31'b0, cmd_ready}, 32'd1);
        chk("b2b_psel_gap",  {31'b0, PSELx},     32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_paddr2", {28'b0, PADDR},     32'd2);
        chk("b2b_psel2",  {31'b0, PSELx},     32'd1);
        chk("b2b_rsp_gap", {31'b0, rsp_valid}, 32'd0);
        tick();
        slave_mem[PADDR] = PWDATA;
        ref_mem[2] = 32'h22222222;
        tick();
        chk("b2b_rsp2", {31'b0, rsp_valid}, 32'd1);
        PREADY = 1'b0;
        tick();
        xfer(1'b0, 4'd1, 32'h0, 1);
        xfer(1'b0, 4'd2, 32'h0, 0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            rw = 1'($urandom);
            ra = 4'($urandom);
            rd = $urandom;
            xfer(rw, ra, rd, $urandom_range(0, 3));
        end

        // Reset during ACCESS drops the command silently
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'd7;
        PREADY    = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        chk("mid_rst_ready",   {31'b0, cmd_ready}, 32'd1);
        chk("mid_rst_psel",    {31'b0, PSELx},     32'd0);
        chk("mid_rst_penable", {31'b0, PENABLE},   32'd0);
        chk("mid_rst_paddr",   {28'b0, PADDR},     32'd0);
        chk("mid_rst_rsp",     {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_rdata",   rsp_rdata,          32'd0);
        tick();
        chk("mid_rst_no_rsp",  {31'b0, rsp_valid}, 32'd0);

        xfer(1'b1, 4'd3, 32'hA5A50001, 0);
        xfer(1'b0, 4'd3, 32'h0, 0);

`ifdef APB_MASTER_TIMEOUT_EN
        // Stuck slave: abort on the 16th wait edge
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'd3;
        PREADY    = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i < 16) begin
                chk("to_wait_rsp",  {31'b0, rsp_valid}, 32'd0);
                chk("to_wait_psel", {31'b0, PSELx},     32'd1);
            end else begin
                chk("to_rsp",     {31'b0, rsp_valid}, 32'd1);
                chk("to_error",   {31'b0, rsp_error}, 32'd1);
                chk("to_rdata",   rsp_rdata,          32'd0);
                chk("to_psel",    {31'b0, PSELx},     32'd0);
                chk("to_penable", {31'b0, PENABLE},   32'd0);
                chk("to_ready",   {31'b0, cmd_ready}, 32'd1);
            end
        end
        tick();
        // PREADY on the terminal edge completes normally
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) begin
                PREADY = 1'b1;
                PRDATA = 32'h5A5A5A5A;
            end
            tick();
            if (i < 16) chk("cw_wait_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        PREADY = 1'b0;
        chk("cw_rsp",   {31'b0, rsp_valid}, 32'd1);
        chk("cw_error", {31'b0, rsp_error}, 32'd0);
        chk("cw_rdata", rsp_rdata,          32'h5A5A5A5A);
        tick();
`else
        // Without the timeout the master waits indefinitely
        begin
            int unsigned seen;
            seen = 0;
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = 4'd3;
            PREADY    = 1'b0;
            tick();
            cmd_valid = 1'b0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (rsp_valid) seen++;
            end
            chk("no_timeout_rsp",  seen,                0);
            chk("no_timeout_psel", {31'b0, PSELx},     32'd1);
            chk("no_timeout_err",  {31'b0, rsp_error}, 32'd0);
            PRESET = 1'b1;
            tick();
            PRESET = 1'b0;
            tick();
        end
`endif
        xfer(1'b0, 4'd4, 32'h0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
